// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the control unit and its phase sequencer.
//   - seq_state_t    : phase sequencer state encoding
//   - instr_class_t  : 3-bit instruction class produced by cu_class_dec
//   - opcode / funct / regimm constants (MIPS-I subset used by the core)
//   - phase_vec()    : maps a sequencer state to the one-hot phase vector p
package cu_pkg;

   typedef enum logic [2:0] {
      ST_P0       = 3'd0,   // fetch
      ST_P1       = 3'd1,   // decode
      ST_P2       = 3'd2,   // execute
      ST_P3       = 3'd3,   // memory
      ST_P4       = 3'd4,   // writeback
      ST_MDU_WAIT = 3'd5,   // waiting on mult/div unit
      ST_EXC      = 3'd6    // exception, one cycle
   } seq_state_t;

   typedef enum logic [2:0] {
      CLS_R   = 3'd0,
      CLS_I   = 3'd1,
      CLS_LD  = 3'd2,
      CLS_ST  = 3'd3,
      CLS_BR  = 3'd4,
      CLS_JMP = 3'd5,
      CLS_MDU = 3'd6,
      CLS_ILL = 3'd7
   } instr_class_t;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LB     = 6'h20;
   localparam logic [5:0] OP_LH     = 6'h21;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_LBU    = 6'h24;
   localparam logic [5:0] OP_LHU    = 6'h25;
   localparam logic [5:0] OP_SB     = 6'h28;
   localparam logic [5:0] OP_SH     = 6'h29;
   localparam logic [5:0] OP_SW     = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   // REGIMM rt field codes (IR[20:16])
   localparam logic [4:0] RT_BLTZ = 5'h00;
   localparam logic [4:0] RT_BGEZ = 5'h01;

   // One-hot phase vector for a state; the wait and exception states drive
   // no phase so the datapath does nothing while in them.
   function automatic logic [4:0] phase_vec(input seq_state_t s);
      case (s)
         ST_P0:   return 5'b00001;
         ST_P1:   return 5'b00010;
         ST_P2:   return 5'b00100;
         ST_P3:   return 5'b01000;
         ST_P4:   return 5'b10000;
         default: return 5'b00000;
      endcase
   endfunction

endpackage

// File: rtl/cu_phase_seq_if.sv
// cu_phase_seq_if: signal bundle between the control unit (master) and the
// phase sequencer (slave).
//   master drives : op, irfunc, regimm, error, imem_ready, dmem_ready
//   slave drives  : p, mdu_busy, instr_done, exc_ovf, exc_ill, retired, stall_cnt
// Handshake: imem_ready / dmem_ready are level "data valid / access done"
// indications; the sequencer holds its phase every cycle they are low (when
// waiting is enabled) and moves on in the first cycle they are sampled high.
interface cu_phase_seq_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       op;
   logic [5:0]       irfunc;
   logic [4:0]       regimm;
   logic             error;
   logic             imem_ready;
   logic             dmem_ready;
   logic [4:0]       p;
   logic             mdu_busy;
   logic             instr_done;
   logic             exc_ovf;
   logic             exc_ill;
   logic [CNT_W-1:0] retired;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output op, irfunc, regimm, error, imem_ready, dmem_ready,
      input  p, mdu_busy, instr_done, exc_ovf, exc_ill, retired, stall_cnt
   );

   modport slave (
      input  op, irfunc, regimm, error, imem_ready, dmem_ready,
      output p, mdu_busy, instr_done, exc_ovf, exc_ill, retired, stall_cnt
   );
endinterface

// File: rtl/cu_class_dec.sv
// cu_class_dec: purely combinational instruction classifier.
//   op        in  6  IR[31:26]
//   irfunc    in  6  IR[5:0]
//   regimm    in  5  IR[20:16]
//   cls       out 3  instruction class (instr_class_t)
//   is_addsub out 1  instruction is a trapping add/sub (overflow checked)
// Any encoding not listed below is classed as illegal.
module cu_class_dec
   import cu_pkg::*;
(
   input  logic [5:0]   op,
   input  logic [5:0]   irfunc,
   input  logic [4:0]   regimm,
   output instr_class_t cls,
   output logic         is_addsub
);

   always_comb begin
      cls       = CLS_ILL;
      is_addsub = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (irfunc)
               FN_ADD, FN_SUB: begin
                  cls       = CLS_R;
                  is_addsub = 1'b1;
               end
               FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU,
               FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
               FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO, FN_JR, FN_JALR:
                  cls = CLS_R;
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
                  cls = CLS_MDU;
               default:
                  cls = CLS_ILL;
            endcase
         end
         OP_REGIMM: begin
            if (regimm == RT_BLTZ || regimm == RT_BGEZ) cls = CLS_BR;
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
            cls = CLS_BR;
         OP_J, OP_JAL:
            cls = CLS_JMP;
         OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI:
            cls = CLS_I;
         OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU:
            cls = CLS_LD;
         OP_SW, OP_SH, OP_SB:
            cls = CLS_ST;
         default:
            cls = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/cu_phase_seq.sv
// cu_phase_seq: phase sequencer for the multi-cycle MIPS core.
// Parameters:
//   MDU_LAT   cycles spent in MDU_WAIT between P2 and P4 (1..255)
//   IMEM_WAIT 1 = P0 holds until imem_ready
//   DMEM_WAIT 1 = P3 holds until dmem_ready
//   CNT_W     width of retired / stall_cnt
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   bus        slave modport of cu_phase_seq_if (instruction fields, memory
//              ready strobes, phase vector, pulses and statistics counters)
//   dbg_state  out  current sequencer state
// p, mdu_busy, exc_ovf and exc_ill are decoded only from registered state.
// instr_done is also registered-state based, except for a store leaving P3,
// where it must coincide with the cycle dmem_ready is seen.
module cu_phase_seq
   import cu_pkg::*;
#(
   parameter int MDU_LAT   = 32,
   parameter int IMEM_WAIT = 1,
   parameter int DMEM_WAIT = 1,
   parameter int CNT_W     = 32
) (
   input  logic          clk,
   input  logic          reset,
   cu_phase_seq_if.slave bus,
   output seq_state_t    dbg_state
);

   // Counter is loaded with MDU_LAT-1 and the exit happens on the cycle it
   // reads zero, giving exactly MDU_LAT cycles in MDU_WAIT.
   localparam logic [7:0] MDU_LOAD = 8'(MDU_LAT - 1);

   seq_state_t       state_q, state_d;
   instr_class_t     cls_q, cls_d;
   logic             addsub_q, addsub_d;
   logic             exc_is_ovf_q, exc_is_ovf_d;
   logic [7:0]       mdu_cnt_q, mdu_cnt_d;
   logic [CNT_W-1:0] retired_q;
   logic [CNT_W-1:0] stall_q;

   instr_class_t     dec_cls;
   logic             dec_addsub;
   logic             done;
   logic             stall;
   logic             imem_hold;
   logic             dmem_hold;

   cu_class_dec u_class_dec (
      .op        (bus.op),
      .irfunc    (bus.irfunc),
      .regimm    (bus.regimm),
      .cls       (dec_cls),
      .is_addsub (dec_addsub)
   );

   assign imem_hold = (IMEM_WAIT != 0) && !bus.imem_ready;
   assign dmem_hold = (DMEM_WAIT != 0) && !bus.dmem_ready;

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      cls_d        = cls_q;
      addsub_d     = addsub_q;
      exc_is_ovf_d = exc_is_ovf_q;
      mdu_cnt_d    = mdu_cnt_q;
      done         = 1'b0;
      stall        = 1'b0;
      case (state_q)
         ST_P0: begin
            if (imem_hold) stall   = 1'b1;
            else           state_d = ST_P1;
         end
         ST_P1: begin
            // Class is captured here so later phases do not depend on IR.
            cls_d    = dec_cls;
            addsub_d = dec_addsub;
            if (dec_cls == CLS_ILL) begin
               state_d      = ST_EXC;
               exc_is_ovf_d = 1'b0;
            end else begin
               state_d = ST_P2;
            end
         end
         ST_P2: begin
            case (cls_q)
               CLS_BR: begin
                  state_d = ST_P0;
                  done    = 1'b1;
               end
               CLS_R, CLS_I: begin
                  if (addsub_q && bus.error) begin
                     state_d      = ST_EXC;
                     exc_is_ovf_d = 1'b1;
                  end else begin
                     state_d = ST_P4;
                  end
               end
               CLS_LD, CLS_ST: state_d = ST_P3;
               CLS_JMP:        state_d = ST_P4;
               CLS_MDU: begin
                  state_d   = ST_MDU_WAIT;
                  mdu_cnt_d = MDU_LOAD;
               end
               default:        state_d = ST_P0;
            endcase
         end
         ST_MDU_WAIT: begin
            if (mdu_cnt_q == 8'd0) state_d   = ST_P4;
            else                   mdu_cnt_d = mdu_cnt_q - 8'd1;
         end
         ST_P3: begin
            if (dmem_hold) begin
               stall = 1'b1;
            end else if (cls_q == CLS_ST) begin
               state_d = ST_P0;
               done    = 1'b1;
            end else begin
               state_d = ST_P4;
            end
         end
         ST_P4: begin
            state_d = ST_P0;
            done    = 1'b1;
         end
         ST_EXC:  state_d = ST_P0;
         default: state_d = ST_P0;
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_P0;
         cls_q        <= CLS_R;
         addsub_q     <= 1'b0;
         exc_is_ovf_q <= 1'b0;
         mdu_cnt_q    <= 8'd0;
         retired_q    <= '0;
         stall_q      <= '0;
      end else begin
         state_q      <= state_d;
         cls_q        <= cls_d;
         addsub_q     <= addsub_d;
         exc_is_ovf_q <= exc_is_ovf_d;
         mdu_cnt_q    <= mdu_cnt_d;
         if (done)  retired_q <= retired_q + CNT_W'(1);
         if (stall) stall_q   <= stall_q + CNT_W'(1);
      end
   end

   assign bus.p          = phase_vec(state_q);
   assign bus.mdu_busy   = (state_q == ST_MDU_WAIT);
   assign bus.instr_done = done;
   assign bus.exc_ovf    = (state_q == ST_EXC) &&  exc_is_ovf_q;
   assign bus.exc_ill    = (state_q == ST_EXC) && !exc_is_ovf_q;
   assign bus.retired    = retired_q;
   assign bus.stall_cnt  = stall_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_cu_phase_seq.sv
// tb_cu_phase_seq: directed scenarios followed by randomized instruction
// streams with random memory stalls and overflow flags. Each instruction is
// expanded into a per-cycle plan (stimulus + expected outputs) from its
// class and latency rules, then played against the sequencer.
module tb_cu_phase_seq;
   import cu_pkg::*;

   localparam int LAT   = 4;
   localparam int CNT_W = 32;

   localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3;
   localparam int K_BR = 4, K_JMP = 5, K_MDU = 6, K_ILL = 7;

   localparam logic [5:0] R_FN  [0:18] = '{6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11,
      6'h12, 6'h13, 6'h08, 6'h09};
   localparam logic [5:0] I_OP  [0:6]  = '{6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F};
   localparam logic [5:0] LD_OP [0:4]  = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25};
   localparam logic [5:0] ST_OP [0:2]  = '{6'h2B, 6'h29, 6'h28};
   localparam logic [5:0] BR_OP [0:3]  = '{6'h04, 6'h05, 6'h06, 6'h07};
   localparam logic [5:0] MD_FN [0:3]  = '{6'h18, 6'h19, 6'h1A, 6'h1B};

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rt;
      int         cls;
      bit         addsub;
      bit         fix_fn;
      bit         fix_rt;
   } ent_t;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset;
   seq_state_t dbg_state;

   always #5 clk = ~clk;

   cu_phase_seq_if #(.CNT_W(CNT_W)) bus ();

   cu_phase_seq #(
      .MDU_LAT   (LAT),
      .IMEM_WAIT (1),
      .DMEM_WAIT (1),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   // exp_q entry: {p[4:0], mdu_busy, instr_done, exc_ovf, exc_ill}
   // stim_q entry: {imem_ready, dmem_ready, error, stall_expected}
   logic [8:0] exp_q[$];
   logic [3:0] stim_q[$];
   ent_t       tbl[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         exp_ret  = 0;
   int         exp_stl  = 0;
   int         idx_add, idx_sub, idx_lw, idx_beq, idx_sw, idx_mult, idx_bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic add_ent(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                          input int cls, input bit addsub, input bit fix_fn, input bit fix_rt);
      ent_t e;
      e.op = op; e.fn = fn; e.rt = rt; e.cls = cls;
      e.addsub = addsub; e.fix_fn = fix_fn; e.fix_rt = fix_rt;
      tbl.push_back(e);
   endtask

   task automatic build_table();
      idx_add = tbl.size(); add_ent(6'h00, 6'h20, 5'h0, K_R, 1, 1, 0);
      idx_sub = tbl.size(); add_ent(6'h00, 6'h22, 5'h0, K_R, 1, 1, 0);
      foreach (R_FN[i])  add_ent(6'h00, R_FN[i], 5'h0, K_R, 0, 1, 0);
      foreach (I_OP[i])  add_ent(I_OP[i], 6'h0, 5'h0, K_I, 0, 0, 0);
      idx_lw = tbl.size();
      foreach (LD_OP[i]) add_ent(LD_OP[i], 6'h0, 5'h0, K_LD, 0, 0, 0);
      idx_sw = tbl.size();
      foreach (ST_OP[i]) add_ent(ST_OP[i], 6'h0, 5'h0, K_ST, 0, 0, 0);
      idx_beq = tbl.size();
      foreach (BR_OP[i]) add_ent(BR_OP[i], 6'h0, 5'h0, K_BR, 0, 0, 0);
      add_ent(6'h01, 6'h0, 5'h00, K_BR, 0, 0, 1);
      add_ent(6'h01, 6'h0, 5'h01, K_BR, 0, 0, 1);
      add_ent(6'h02, 6'h0, 5'h0, K_JMP, 0, 0, 0);
      add_ent(6'h03, 6'h0, 5'h0, K_JMP, 0, 0, 0);
      idx_mult = tbl.size();
      foreach (MD_FN[i]) add_ent(6'h00, MD_FN[i], 5'h0, K_MDU, 0, 1, 0);
      idx_bad = tbl.size();
      add_ent(6'h3F, 6'h0, 5'h0, K_ILL, 0, 0, 0);
      add_ent(6'h00, 6'h01, 5'h0, K_ILL, 0, 1, 0);
      add_ent(6'h01, 6'h0, 5'h10, K_ILL, 0, 0, 1);
      add_ent(6'h30, 6'h0, 5'h0, K_ILL, 0, 0, 0);
   endtask

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   task automatic plan(input bit im, input bit dm, input bit er, input logic [4:0] pp,
                       input bit busy, input bit done, input bit ovf, input bit ill, input bit stl);
      stim_q.push_back({im, dm, er, stl});
      exp_q.push_back({pp, busy, done, ovf, ill});
   endtask

   // Build the cycle-by-cycle plan for one instruction, then play it.
   // abort_at >= 0 pulls reset low after that plan cycle.
   task automatic run_instr(input int k, input int istall, input int dstall,
                            input bit err, input int abort_at);
      ent_t       e;
      logic [8:0] ex;
      logic [3:0] st;
      int         c;
      e = tbl[k];
      exp_q.delete();
      stim_q.delete();
      for (int i = 0; i < istall; i++) plan(0, rb(), rb(), 5'b00001, 0, 0, 0, 0, 1);
      plan(1, rb(), rb(), 5'b00001, 0, 0, 0, 0, 0);
      plan(rb(), rb(), rb(), 5'b00010, 0, 0, 0, 0, 0);
      if (e.cls == K_ILL) begin
         plan(rb(), rb(), rb(), 5'b00000, 0, 0, 0, 1, 0);
      end else begin
         plan(rb(), rb(), err, 5'b00100, 0, (e.cls == K_BR), 0, 0, 0);
         case (e.cls)
            K_R, K_I: begin
               if (e.addsub && err) plan(rb(), rb(), rb(), 5'b00000, 0, 0, 1, 0, 0);
               else                 plan(rb(), rb(), rb(), 5'b10000, 0, 1, 0, 0, 0);
            end
            K_LD, K_ST: begin
               for (int i = 0; i < dstall; i++) plan(rb(), 0, rb(), 5'b01000, 0, 0, 0, 0, 1);
               plan(rb(), 1, rb(), 5'b01000, 0, (e.cls == K_ST), 0, 0, 0);
               if (e.cls == K_LD) plan(rb(), rb(), rb(), 5'b10000, 0, 1, 0, 0, 0);
            end
            K_JMP: plan(rb(), rb(), rb(), 5'b10000, 0, 1, 0, 0, 0);
            K_MDU: begin
               for (int i = 0; i < LAT; i++) plan(rb(), rb(), rb(), 5'b00000, 1, 0, 0, 0, 0);
               plan(rb(), rb(), rb(), 5'b10000, 0, 1, 0, 0, 0);
            end
            default: ;
         endcase
      end

      bus.op     = e.op;
      bus.irfunc = e.fix_fn ? e.fn : 6'($urandom_range(0, 63));
      bus.regimm = e.fix_rt ? e.rt : 5'($urandom_range(0, 31));
      c = 0;
      while (exp_q.size() > 0) begin
         ex = exp_q.pop_front();
         st = stim_q.pop_front();
         bus.imem_ready = st[3];
         bus.dmem_ready = st[2];
         bus.error      = st[1];
         #1;
         check("p",          32'(bus.p),          32'(ex[8:4]));
         check("mdu_busy",   32'(bus.mdu_busy),   32'(ex[3]));
         check("instr_done", 32'(bus.instr_done), 32'(ex[2]));
         check("exc_ovf",    32'(bus.exc_ovf),    32'(ex[1]));
         check("exc_ill",    32'(bus.exc_ill),    32'(ex[0]));
         check("retired",    bus.retired,         32'(exp_ret));
         check("stall_cnt",  bus.stall_cnt,       32'(exp_stl));
         if (ex[2]) exp_ret++;
         if (st[0]) exp_stl++;
         if (c == abort_at) begin
            reset = 1'b0;
            @(posedge clk);
            #1;
            check("rst_p",        32'(bus.p),          32'h1);
            check("rst_mdu_busy", 32'(bus.mdu_busy),   32'h0);
            check("rst_exc",      32'({bus.exc_ovf, bus.exc_ill}), 32'h0);
            check("rst_retired",  bus.retired,         32'h0);
            check("rst_stall",    bus.stall_cnt,       32'h0);
            reset   = 1'b1;
            exp_ret = 0;
            exp_stl = 0;
            exp_q.delete();
            stim_q.delete();
            return;
         end
         c++;
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int k, is, ds;
      reset          = 1'b0;
      bus.op         = 6'h0;
      bus.irfunc     = 6'h0;
      bus.regimm     = 5'h0;
      bus.error      = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      build_table();

      repeat (2) @(posedge clk);
      #1;
      check("reset_p",        32'(bus.p),          32'h1);
      check("reset_busy",     32'(bus.mdu_busy),   32'h0);
      check("reset_done",     32'(bus.instr_done), 32'h0);
      check("reset_exc",      32'({bus.exc_ovf, bus.exc_ill}), 32'h0);
      check("reset_retired",  bus.retired,         32'h0);
      check("reset_stall",    bus.stall_cnt,       32'h0);
      reset = 1'b1;

      // Directed scenarios
      run_instr(idx_add,  0, 0, 0, -1);   // add, 4 cycles
      run_instr(idx_lw,   0, 3, 0, -1);   // lw with 3 dmem stall cycles
      run_instr(idx_beq,  0, 0, 0, -1);   // beq, 3 cycles
      run_instr(idx_sw,   0, 0, 0, -1);   // sw, 4 cycles
      run_instr(idx_mult, 0, 0, 0, -1);   // mult, 4 + LAT cycles
      run_instr(idx_add,  0, 0, 1, -1);   // add overflow -> EXC
      run_instr(idx_sub,  2, 0, 1, -1);   // sub overflow with fetch stall
      run_instr(idx_bad,  0, 0, 0, -1);   // illegal opcode
      run_instr(idx_mult, 1, 0, 0, 4);    // reset while in MDU_WAIT
      run_instr(idx_add,  0, 0, 0, -1);   // normal operation after reset

      // Randomized stream
      for (int n = 0; n < 400; n++) begin
         k  = $urandom_range(0, tbl.size() - 1);
         is = rb() ? 0 : $urandom_range(1, 3);
         ds = rb() ? 0 : $urandom_range(1, 3);
         run_instr(k, is, ds, rb(), -1);
      end

      check("final_retired", bus.retired,   32'(exp_ret));
      check("final_stall",   bus.stall_cnt, 32'(exp_stl));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cu_phase_seq.md
Name: cu_phase_seq

Overview:
- Sequential phase generator for the multi-cycle MIPS core.
- Produces the one-hot phase vector p consumed by CU, which it drives directly.
- Replaces the fixed 5-phase loop with per-class phase skipping, plus memory-ready stalls, a multi-cycle MDU wait, and overflow/illegal-instruction exception states.
- Also keeps retired-instruction and stall-cycle counters for bring-up.

Parameters:
- MDU_LAT, 32: cycles the mult/div unit needs after p2 before the HI/LO write in p4 (legal range 1..255).
- IMEM_WAIT, 1: 1 = p0 holds until imem_ready; 0 = imem_ready is ignored (treated as 1).
- DMEM_WAIT, 1: 1 = p3 holds until dmem_ready for loads/stores; 0 = dmem_ready is ignored.
- CNT_W, 32: width of the retired and stall counters.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-low reset; sampled on rising clk.
- op, in, 6: IR[31:26], stable from p1 onward.
- irfunc, in, 6: IR[5:0].
- regimm, in, 5: IR[20:16].
- error, in, 1: ALU overflow, valid in p2.
- imem_ready, in, 1: instruction memory data valid.
- dmem_ready, in, 1: data memory access complete.
- p, out, 5: one-hot phase (p[0]=fetch .. p[4]=writeback); all-zero in MDU_WAIT and EXC.
- mdu_busy, out, 1: high while in MDU_WAIT.
- instr_done, out, 1: one-cycle pulse on the last phase of a retired instruction.
- exc_ovf, out, 1: one-cycle pulse, add/sub overflow.
- exc_ill, out, 1: one-cycle pulse, undecodable instruction.
- retired, out, CNT_W: count of retired instructions; wraps modulo 2^CNT_W.
- stall_cnt, out, CNT_W: count of cycles spent holding for imem_ready/dmem_ready; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0 at a clk edge, from any state including mid-MDU wait or a memory stall):
  - state=P0, p=5'b00001.
  - mdu_busy=0, instr_done=0, exc_ovf=0, exc_ill=0, retired=0, stall_cnt=0, MDU counter=0.
- States: P0, P1, P2, P3, P4, MDU_WAIT, EXC.
  - In P0..P4, p is one-hot on the matching bit.
  - Outputs are registered; p changes only on clk edges.
- P0 (fetch):
  - If IMEM_WAIT and !imem_ready: hold and increment stall_cnt.
  - Otherwise go to P1.
- P1 (decode): the instruction class is decoded from op/irfunc/regimm and registered at the P1 exit edge. Classes:
  - R: add, sub, subu, and, or, xor, nor, slt, sltu, shifts, mfhi, mflo, mthi, mtlo, jr, jalr.
  - I: addiu, andi, ori, xori, slti, sltiu, lui.
  - LD: lw, lb, lbu, lh, lhu.
  - ST: sw, sh, sb.
  - BR: beq, bne, bgez, bgtz, blez, bltz.
  - JMP: j, jal.
  - MDU: mult, multu, div, divu.
  - ILL: anything else.
- P1 exit: ILL goes to EXC with exc_ill pulsed on entry; every other class goes to P2.
- P2 (execute) exit:
  - BR: go to P0; instr_done=1 in this last P2 cycle.
  - R/I: if (add|sub) && error, go to EXC with exc_ovf pulsed; otherwise go to P4, skipping P3.
  - LD/ST: go to P3.
  - JMP: go to P4.
  - MDU: go to MDU_WAIT with the counter loaded to MDU_LAT-1.
- MDU_WAIT:
  - p=0, mdu_busy=1; the counter decrements each cycle.
  - At counter==0, go to P4.
  - Total cycles spent in MDU_WAIT = MDU_LAT.
- P3 (memory):
  - If DMEM_WAIT and !dmem_ready: hold and increment stall_cnt.
  - Otherwise ST goes to P0 (instr_done=1 in this cycle) and LD goes to P4.
- P4 (writeback): one cycle, then P0 with instr_done=1.
- EXC: one cycle, p=0; no writeback, retired unchanged; then P0.
- retired increments on every cycle where instr_done=1.
- instr_done, exc_ovf and exc_ill are never high in the same cycle.
- Nominal latencies (no stalls): BR=3, ST=4, R/I/JMP=4, LD=5, MDU=4+MDU_LAT.
- Counters wrap; there is no saturation.

Decomposition:
- Shared package cu_pkg:
  - State encoding.
  - Class encoding (3-bit).
  - Opcode/funct/regimm constants, shared with CU to remove duplicated literals.
- Sub-module cu_class_dec: purely combinational op/irfunc/regimm to class. It is reused by CU later.
- Sequencer FSM, MDU counter and statistics counters stay in cu_phase_seq.

Test Plan:
- Reset then add (op=0, irfunc=0x20, error=0), memories always ready -> p sequence 00001, 00010, 00100, 10000, 00001; instr_done on the 4th cycle; retired=1.
- lw with dmem_ready low for 3 P3 cycles -> p holds 01000 for 4 cycles; stall_cnt=3; total latency 8; retired=1.
- beq followed by sw -> beq retires after 3 cycles with p skipping P3 and P4; sw shows P0..P3 then P0; retired=2 after 7 cycles.
- mult with MDU_LAT=4 -> p=0 and mdu_busy=1 for exactly 4 cycles after P2, then P4; latency 8.
- add with error=1 in P2 -> EXC one cycle, exc_ovf pulse, no P4, retired unchanged.
- op=6'b111111 -> exc_ill pulse after P1.
- reset deasserted-then-asserted (reset=0) while in MDU_WAIT -> next edge p=00001 and all counters 0.
